// File: rtl/phase_sequencer_pkg.sv
// phase_seq_pkg: shared types, limits and width helper for the phase sequencer.
package phase_seq_pkg;

    localparam int MAX_PHASES = 16;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} seq_state_t;

    // Bit width for a value range of n, never narrower than one bit.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// phase_sequencer_if: control/status bundle of the phase sequencer.
// Carries I_cnt_clr / O_lock_loss_cnt only when PHASE_SEQ_LOCK_LOSS_CNT_EN is defined.
interface phase_sequencer_if import phase_seq_pkg::*; #(
    parameter int NUM_PHASES = 3,
    parameter int DIV_WIDTH  = 8
);
    logic                                  I_pll_lock;
    logic                                  I_enable;
    logic [DIV_WIDTH-1:0]                  I_div;
    logic [NUM_PHASES-1:0]                 O_phase;
    logic [clog2_safe(NUM_PHASES)-1:0]     O_phase_idx;
    logic                                  O_tick;
    logic                                  O_wrap;
    logic                                  O_ready;
    logic                                  O_N_reset;
`ifdef PHASE_SEQ_LOCK_LOSS_CNT_EN
    logic                                  I_cnt_clr;
    logic [7:0]                            O_lock_loss_cnt;
`endif

    modport master (
        output I_pll_lock, I_enable, I_div,
        input  O_phase, O_phase_idx, O_tick, O_wrap, O_ready, O_N_reset
`ifdef PHASE_SEQ_LOCK_LOSS_CNT_EN
        , output I_cnt_clr, input O_lock_loss_cnt
`endif
    );

    modport slave (
        input  I_pll_lock, I_enable, I_div,
        output O_phase, O_phase_idx, O_tick, O_wrap, O_ready, O_N_reset
`ifdef PHASE_SEQ_LOCK_LOSS_CNT_EN
        , input I_cnt_clr, output O_lock_loss_cnt
`endif
    );

endinterface

// File: rtl/phase_sequencer_lock_filter.sv
// lock_filter: qualifies PLL lock after LOCK_CYCLES consecutive high cycles.
module lock_filter import phase_seq_pkg::*; #(
    parameter int LOCK_CYCLES = 16
) (
    input  logic I_clock,
    input  logic I_rst,
    input  logic I_pll_lock,
    output logic O_ready
);
    localparam int            CW    = clog2_safe(LOCK_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(LOCK_CYCLES);

    logic [CW-1:0] cnt;

    // Any low lock sample restarts qualification; no hysteresis.
    always_ff @(posedge I_clock) begin
        if (I_rst) begin
            cnt     <= '0;
            O_ready <= 1'b0;
        end else begin
            cnt     <= !I_pll_lock ? '0 : (cnt == LIMIT) ? cnt : cnt + 1'b1;
            O_ready <= I_pll_lock && (cnt == LIMIT);
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// phase_sequencer: lock-gated N-phase one-hot rotator with programmable step divider.
// Define PHASE_SEQ_LOCK_LOSS_CNT_EN to add the saturating lock-loss counter.
module phase_sequencer import phase_seq_pkg::*; #(
    parameter int NUM_PHASES  = 3,
    parameter int DIV_WIDTH   = 8,
    parameter int LOCK_CYCLES = 16
) (
    input logic                I_clock,
    input logic                I_rst,
    phase_sequencer_if.slave   bus
);
    localparam int            IW   = clog2_safe(NUM_PHASES);
    localparam logic [IW-1:0] LAST = IW'(NUM_PHASES - 1);

    if (NUM_PHASES < 2 || NUM_PHASES > MAX_PHASES) begin : g_np_check
        $error("NUM_PHASES out of range");
    end

    logic                  ready;
    logic                  n_reset;
    logic                  tick;
    logic                  wrap;
    logic                  term;
    logic [NUM_PHASES-1:0] phase;
    logic [IW-1:0]         idx;
    logic [DIV_WIDTH-1:0]  pre;
    logic [DIV_WIDTH-1:0]  div_latched;
    logic [DIV_WIDTH-1:0]  div_in;
    logic [DIV_WIDTH-1:0]  div_eff;
    seq_state_t            st;
    seq_state_t            st_n;

    lock_filter #(.LOCK_CYCLES(LOCK_CYCLES)) u_lock_filter (
        .I_clock    (I_clock),
        .I_rst      (I_rst),
        .I_pll_lock (bus.I_pll_lock),
        .O_ready    (ready)
    );

    // st_n is the state acting at this edge; a lock drop forces IDLE immediately,
    // so it pre-empts a coincident terminal count. st holds the previous one.
    always_comb begin
        st_n    = (!ready || !bus.I_pll_lock) ? IDLE : bus.I_enable ? RUN : HOLD;
        div_in  = (bus.I_div == '0) ? DIV_WIDTH'(1) : bus.I_div;
        div_eff = (st == IDLE) ? div_in : div_latched;
        term    = (st_n == RUN) && (pre >= div_eff - 1'b1);
    end

    always_ff @(posedge I_clock) begin
        if (I_rst) begin
            st          <= IDLE;
            phase       <= NUM_PHASES'(1);
            idx         <= '0;
            pre         <= '0;
            div_latched <= DIV_WIDTH'(1);
            tick        <= 1'b0;
            wrap        <= 1'b0;
            n_reset     <= 1'b0;
        end else begin
            st      <= st_n;
            n_reset <= ready;
            tick    <= term;
            wrap    <= term && (idx == LAST);
            if (((st == IDLE) && (st_n == RUN)) || (term && (idx == LAST)))
                div_latched <= div_in;
            if (st_n == IDLE) begin
                phase <= NUM_PHASES'(1);
                idx   <= '0;
                pre   <= '0;
            end else if (term) begin
                pre   <= '0;
                phase <= {phase[NUM_PHASES-2:0], phase[NUM_PHASES-1]};
                idx   <= (idx == LAST) ? '0 : idx + 1'b1;
            end else if (st_n == RUN) begin
                pre <= pre + 1'b1;
            end
        end
    end

    assign bus.O_phase     = phase;
    assign bus.O_phase_idx = idx;
    assign bus.O_tick      = tick;
    assign bus.O_wrap      = wrap;
    assign bus.O_ready     = ready;
    assign bus.O_N_reset   = n_reset;

`ifdef PHASE_SEQ_LOCK_LOSS_CNT_EN
    logic [7:0] loss_cnt;

    // Counts at the edge where ready falls; clear wins over a coincident drop.
    always_ff @(posedge I_clock) begin
        if (I_rst || bus.I_cnt_clr)
            loss_cnt <= '0;
        else if (ready && !bus.I_pll_lock && (loss_cnt != 8'hff))
            loss_cnt <= loss_cnt + 1'b1;
    end

    assign bus.O_lock_loss_cnt = loss_cnt;
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: directed scenarios plus random traffic against a cycle-level
// integer model of the lock filter, step divider and phase rotation.
module tb_phase_sequencer;
    localparam int NP = 3;
    localparam int DW = 8;
    localparam int LC = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    phase_sequencer_if #(.NUM_PHASES(NP), .DIV_WIDTH(DW)) bus();

    phase_sequencer #(.NUM_PHASES(NP), .DIV_WIDTH(DW), .LOCK_CYCLES(LC)) dut (
        .I_clock (clk),
        .I_rst   (rst),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    int run_len, m_ready, m_nres, m_idx, m_el, m_div, m_tick, m_wrap, m_prev_idle, m_loss;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: advance the model from the pre-edge inputs, then compare outputs.
    task automatic step();
        int dv, period;
        bit go, clr;
        @(posedge clk);
        clr = 1'b0;
`ifdef PHASE_SEQ_LOCK_LOSS_CNT_EN
        clr = bus.I_cnt_clr;
`endif
        if (rst) begin
            run_len = 0; m_ready = 0; m_nres = 0; m_idx = 0; m_el = 0;
            m_div = 1; m_tick = 0; m_wrap = 0; m_prev_idle = 1; m_loss = 0;
        end else begin
            dv = (bus.I_div == 0) ? 1 : int'(bus.I_div);
            go = (m_ready != 0) && bus.I_pll_lock;
            if (clr) m_loss = 0;
            else if (m_ready != 0 && !bus.I_pll_lock && m_loss < 255) m_loss++;
            m_tick = 0;
            m_wrap = 0;
            if (!go) begin
                m_idx = 0; m_el = 0; m_prev_idle = 1;
            end else if (bus.I_enable) begin
                period = m_prev_idle ? dv : m_div;
                if (m_prev_idle) m_div = dv;
                m_el++;
                if (m_el >= period) begin
                    m_el   = 0;
                    m_idx  = (m_idx + 1) % NP;
                    m_tick = 1;
                    m_wrap = (m_idx == 0);
                    if (m_wrap) m_div = dv;
                end
                m_prev_idle = 0;
            end else begin
                m_prev_idle = 0;
            end
            m_nres  = m_ready;
            run_len = bus.I_pll_lock ? run_len + 1 : 0;
            m_ready = (run_len > LC) ? 1 : 0;
        end
        #1;
        check("phase", 32'(bus.O_phase), 32'(1) << m_idx);
        check("idx", 32'(bus.O_phase_idx), m_idx);
        check("tick", 32'(bus.O_tick), m_tick);
        check("wrap", 32'(bus.O_wrap), m_wrap);
        check("ready", 32'(bus.O_ready), m_ready);
        check("n_reset", 32'(bus.O_N_reset), m_nres);
`ifdef PHASE_SEQ_LOCK_LOSS_CNT_EN
        check("loss_cnt", 32'(bus.O_lock_loss_cnt), m_loss);
`endif
    endtask

    initial begin
        int c;
        rst = 1'b1;
        bus.I_pll_lock = 1'b0;
        bus.I_enable   = 1'b0;
        bus.I_div      = 8'd4;
`ifdef PHASE_SEQ_LOCK_LOSS_CNT_EN
        bus.I_cnt_clr  = 1'b0;
`endif
        step();
        step();
        check("rst_phase", 32'(bus.O_phase), 1);
        check("rst_ready", 32'(bus.O_ready), 0);
        rst = 1'b0;

        // Lock qualification timing from reset release.
        bus.I_pll_lock = 1'b1;
        bus.I_enable   = 1'b1;
        c = 0;
        while (!bus.O_ready && c < 40) begin
            step();
            c++;
        end
        check("ready_rise_cycle", c, 17);
        step();
        check("n_reset_rise", 32'(bus.O_N_reset), 1);

        // Rotation at div 4, then mid-sequence divider changes.
        repeat (26) step();
        bus.I_div = 8'd2;
        repeat (30) step();
        bus.I_div = 8'd0;
        repeat (12) step();
        bus.I_div = 8'd4;
        repeat (12) step();

        // One-cycle lock drop at idx 2, then re-qualification.
        c = 0;
        while (!(m_ready != 0 && m_idx == 2) && c < 40) begin
            step();
            c++;
        end
        bus.I_pll_lock = 1'b0;
        step();
        check("drop_ready", 32'(bus.O_ready), 0);
        check("drop_phase", 32'(bus.O_phase), 1);
        check("drop_tick", 32'(bus.O_tick), 0);
        bus.I_pll_lock = 1'b1;
        repeat (16) step();
        check("requal_early", 32'(bus.O_ready), 0);
        step();
        check("requal", 32'(bus.O_ready), 1);

        // Hold at prescaler 2 of 4: next tick two cycles after resuming.
        c = 0;
        while (!bus.O_tick && c < 20) begin
            step();
            c++;
        end
        check("hold_pre_tick", 32'(bus.O_tick), 1);
        step();
        step();
        bus.I_enable = 1'b0;
        repeat (10) begin
            step();
            check("hold_tick", 32'(bus.O_tick), 0);
        end
        bus.I_enable = 1'b1;
        step();
        check("resume_tick1", 32'(bus.O_tick), 0);
        step();
        check("resume_tick2", 32'(bus.O_tick), 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst            = ($urandom_range(0, 499) == 0);
            bus.I_pll_lock = ($urandom_range(0, 99) < 97);
            bus.I_enable   = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) bus.I_div = 8'($urandom_range(0, 5));
`ifdef PHASE_SEQ_LOCK_LOSS_CNT_EN
            bus.I_cnt_clr  = ($urandom_range(0, 199) == 0);
`endif
            step();
        end
        rst = 1'b0;

`ifdef PHASE_SEQ_LOCK_LOSS_CNT_EN
        bus.I_cnt_clr = 1'b0;
        bus.I_enable  = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            bus.I_pll_lock = 1'b1;
            repeat (17) step();
            bus.I_pll_lock = 1'b0;
            step();
        end
        check("loss_three", 32'(bus.O_lock_loss_cnt), 3);
        bus.I_pll_lock = 1'b1;
        repeat (17) step();
        bus.I_pll_lock = 1'b0;
        bus.I_cnt_clr  = 1'b1;
        step();
        bus.I_cnt_clr  = 1'b0;
        check("loss_clr_wins", 32'(bus.O_lock_loss_cnt), 0);
        for (int d = 0; d < 300; d++) begin
            bus.I_pll_lock = 1'b1;
            repeat (17) step();
            bus.I_pll_lock = 1'b0;
            step();
        end
        check("loss_sat", 32'(bus.O_lock_loss_cnt), 255);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
